// File: rtl/bus_arbiter_8way_if.sv
// rtl/bus_arbiter_8way_if.sv - request/grant bundle between eight requesters and the arbiter
interface bus_arbiter_8way_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter_8way.sv
// rtl/bus_arbiter_8way.sv - 8-way round-robin bus arbiter with turnaround cycle
// Optional bounded tenure selected by macro BUS_ARB_TIMEOUT_EN.
module bus_arbiter_8way #(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_8way_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [2:0] pick;
    logic       pick_vld;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter_8way: MAX_HOLD must be within 2..255");
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q,    hold_d;
    logic       timeout_q, timeout_d;
`endif

    // Scan downward so the requester closest to ptr overwrites the others.
    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr_q + 3'(k)]) begin
                pick     = ptr_q + 3'(k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q + 3'd1;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    ptr_d     = owner_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 3'd0;
            ptr_q     <= 3'd0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // sel keeps the last owner through IDLE so the datapath mux does not glitch.
    assign bus.grant = (state_q == GRANT) ? (8'd1 << owner_q) : 8'd0;
    assign bus.sel   = owner_q;
    assign bus.busy  = (state_q == GRANT);
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter_8way.sv
// tb/tb_bus_arbiter_8way.sv - directed and randomized check of bus_arbiter_8way against a reference model
module tb_bus_arbiter_8way;
    localparam int TB_MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bus_arbiter_8way_if ifc ();

    bus_arbiter_8way #(
        .MAX_HOLD(TB_MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus, where the search starts, how long the tenure has run.
    int m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    int m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] rq);
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_busy == 0) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_busy == 0 && rq[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_busy  = 1;
                    m_held  = 0;
                end
            end
        end else begin
            m_to = 0;
            if (!rq[m_owner]) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 8;
            end else begin
                m_held = m_held + 1;
                if (TO_EN && m_held == TB_MAX_HOLD) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 8;
                    m_to   = 1;
                end
            end
        end
    endtask

    task automatic step();
        logic [7:0] eg;
        @(posedge clk);
        model_edge(reset, ifc.req);
        #1;
        eg = (m_busy != 0) ? 8'(1 << m_owner) : 8'h00;
        check("grant", 32'(ifc.grant), 32'(eg));
        check("sel", 32'(ifc.sel), 32'(m_owner));
        check("busy", 32'(ifc.busy), 32'(m_busy));
        check("timeout", 32'(ifc.timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(ifc.grant)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        ifc.req = 8'h00;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;

        do_reset();
        check("rst_grant", 32'(ifc.grant), 32'h0);
        check("rst_sel", 32'(ifc.sel), 32'h0);
        check("rst_busy", 32'(ifc.busy), 32'h0);
        step();
        check("idle_stays", 32'(ifc.busy), 32'h0);

        // Single request, then release: sel must hold 4 while idle.
        ifc.req = 8'h10;
        step();
        check("single_grant", 32'(ifc.grant), 32'h10);
        check("single_sel", 32'(ifc.sel), 32'd4);
        ifc.req = 8'h00;
        step();
        check("single_rel_grant", 32'(ifc.grant), 32'h0);
        check("single_rel_sel", 32'(ifc.sel), 32'd4);

        // Round robin with all requesting, each owner releasing after two cycles.
        do_reset();
        ifc.req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            step();
            check("rr_owner", 32'(ifc.sel), 32'(t % 8));
            check("rr_busy", 32'(ifc.busy), 32'd1);
            step();
            ifc.req = 8'hFF & ~(8'h01 << (t % 8));
            step();
            check("rr_turnaround", 32'(ifc.busy), 32'd0);
            ifc.req = 8'hFF;
        end

        // Pointer wrap: after owner 6, requester 7 precedes requester 0.
        do_reset();
        ifc.req = 8'h40;
        step();
        ifc.req = 8'h00;
        step();
        ifc.req = 8'h81;
        step();
        check("wrap_first", 32'(ifc.sel), 32'd7);
        ifc.req = 8'h01;
        step();
        step();
        check("wrap_second", 32'(ifc.grant), 32'h01);

        // Reset in the middle of a tenure.
        do_reset();
        ifc.req = 8'h08;
        step();
        check("mid_grant", 32'(ifc.grant), 32'h08);
        reset = 1'b1;
        step();
        check("mid_rst_grant", 32'(ifc.grant), 32'h0);
        check("mid_rst_sel", 32'(ifc.sel), 32'd0);
        reset = 1'b0;
        step();
        check("mid_regrant", 32'(ifc.grant), 32'h08);

        // Tenure limit.
        do_reset();
        ifc.req = TO_EN ? 8'h03 : 8'h01;
        if (TO_EN) begin
            for (int c = 0; c < TB_MAX_HOLD; c++) begin
                step();
                check("to_hold", 32'(ifc.grant), 32'h01);
            end
            step();
            check("to_pulse", 32'(ifc.timeout), 32'd1);
            check("to_idle", 32'(ifc.busy), 32'd0);
            step();
            check("to_next", 32'(ifc.grant), 32'h02);
            check("to_clear", 32'(ifc.timeout), 32'd0);
        end else begin
            for (int c = 0; c < 100; c++) begin
                step();
                check("nto_hold", 32'(ifc.grant), 32'h01);
                check("nto_flag", 32'(ifc.timeout), 32'd0);
            end
        end

        // Randomized traffic with occasional resets.
        do_reset();
        ifc.req = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r == 0);
            if (r < 15)
                ifc.req = 8'($urandom);
            else if (r < 30 && m_busy != 0)
                ifc.req = ifc.req & ~(8'h01 << m_owner);
            else if (r < 35)
                ifc.req = 8'h00;
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
